// File: rtl/slc3_io_responder.sv
// Board-side SLC-3 I/O: debounced Run/Continue press pulses (SYNC_STAGES+DEBOUNCE_CYCLES edges), memory-mapped
// switch read (1-cycle registered) / hex register write, and active-low 7-segment decode. No backpressure.
module slc3_io_responder #(
  parameter logic [15:0] IO_ADDR         = 16'hFFFF,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run_n,
  input  logic        Continue_n,
  input  logic [9:0]  SW,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic        OE,
  input  logic        WE,
  output logic [15:0] Data_to_CPU,
  output logic        io_sel,
  output logic        run_pulse,
  output logic        continue_pulse,
  output logic [15:0] hex_reg,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0] pin;
  logic [1:0] pulse;

  assign pin            = {Continue_n, Run_n};
  assign run_pulse      = pulse[0];
  assign continue_pulse = pulse[1];

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   stable_q;
    logic                   pulse_q;
    logic                   s;

    assign s        = sync_q[SYNC_STAGES-1];
    assign pulse[b] = pulse_q;

    // A change is accepted only after s differs from stable for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        sync_q   <= '1;
        cnt_q    <= '0;
        stable_q <= 1'b1;
        pulse_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], pin[b]};
        pulse_q <= 1'b0;
        if (s == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_q <= s;
          cnt_q    <= '0;
          pulse_q  <= ~s;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign io_sel = (ADDR == IO_ADDR);

  // Write has priority over read when both strobes are low.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_reg     <= '0;
      Data_to_CPU <= '0;
    end else if (io_sel && !WE) begin
      hex_reg <= Data_from_CPU;
    end else if (io_sel && !OE) begin
      Data_to_CPU <= {6'b0, SW};
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign HEX0 = seg7(hex_reg[3:0]);
  assign HEX1 = seg7(hex_reg[7:4]);
  assign HEX2 = seg7(hex_reg[11:8]);
  assign HEX3 = seg7(hex_reg[15:12]);

endmodule
